kth_max_tracker: RTL and testbench

//  Parametrised streaming rank-K maximum finder: after start, accepts COUNT samples on a

---
 rtl/kmax_pkg.sv | 17 +
 rtl/kmax_slot.sv | 56 +++++
 rtl/kth_max_tracker.sv | 156 +++++++++++++++
 tb/tb_kth_max_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmax_pkg.sv
// rtl/kmax_pkg.sv - shared FSM state type and rank legality check for kth_max_tracker
package kmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int K_MIN = 1;
    localparam int K_MAX = 8;

    function automatic bit k_legal(input int k);
        return (k >= K_MIN) && (k <= K_MAX);
    endfunction

endpackage

// File: rtl/kmax_slot.sv
// rtl/kmax_slot.sv - one rank register of the sorted top-K list with its slot-valid bit
module kmax_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              ins_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] up_val_i,
    input  logic              up_vld_i,
    input  logic              up_taken_i,
    output logic [DATA_W-1:0] val_o,
    output logic              vld_o,
    output logic              taken_o,
    output logic [DATA_W-1:0] nxt_val_o
);

    logic [DATA_W-1:0] val_q, val_d;
    logic              vld_q, vld_d;

    // An empty slot always accepts; equals do not, so they settle below existing ones.
    assign taken_o = up_taken_i | ~vld_q | (sample_i > val_q);

    always_comb begin
        val_d = val_q;
        vld_d = vld_q;
        if (clear_i) begin
            val_d = '0;
            vld_d = 1'b0;
        end else if (ins_i) begin
            if (up_taken_i) begin
                val_d = up_val_i;
                vld_d = up_vld_i;
            end else if (taken_o) begin
                val_d = sample_i;
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
            vld_q <= 1'b0;
        end else begin
            val_q <= val_d;
            vld_q <= vld_d;
        end
    end

    assign val_o     = val_q;
    assign vld_o     = vld_q;
    assign nxt_val_o = val_d;

endmodule

// File: rtl/kth_max_tracker.sv
// rtl/kth_max_tracker.sv - streaming rank-K maximum finder; RANK_DISTINCT_EN drops duplicate values
module kth_max_tracker
    import kmax_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 2,
    parameter int CNT_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    count,
    input  logic                valid,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ready,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic [K*DATA_W-1:0] top_flat,
    output logic                underfill
);

    localparam int FILL_W = $clog2(K + 1);
`ifdef RANK_DISTINCT_EN
    localparam bit DISTINCT = 1'b1;
`else
    localparam bit DISTINCT = 1'b0;
`endif

    if (!k_legal(K)) begin : g_k_illegal
        $error("kth_max_tracker: K must lie in 1..8");
    end

    state_e              state_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                ready_q, done_q, underfill_q;
    logic [DATA_W-1:0]   result_q;
    logic [K*DATA_W-1:0] top_q;

    logic [DATA_W-1:0]   val     [K];
    logic [DATA_W-1:0]   nxt_val [K];
    logic [DATA_W-1:0]   up_val  [K];
    logic [K-1:0]        vld, taken, up_vld, up_taken;
    logic                clear, ins, dup;
    logic [K*DATA_W-1:0] top_d;
    logic [DATA_W-1:0]   result_d;
    logic                underfill_d;

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign up_val[i]   = '0;
            assign up_vld[i]   = 1'b0;
            assign up_taken[i] = 1'b0;
        end else begin : g_body
            assign up_val[i]   = val[i-1];
            assign up_vld[i]   = vld[i-1];
            assign up_taken[i] = taken[i-1];
        end

        kmax_slot #(.DATA_W(DATA_W)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (clear),
            .ins_i      (ins),
            .sample_i   (data_in),
            .up_val_i   (up_val[i]),
            .up_vld_i   (up_vld[i]),
            .up_taken_i (up_taken[i]),
            .val_o      (val[i]),
            .vld_o      (vld[i]),
            .taken_o    (taken[i]),
            .nxt_val_o  (nxt_val[i])
        );
    end

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (vld[i] && (data_in == val[i])) dup = 1'b1;
        end
    end

    assign clear = (state_q == ST_IDLE) && start;
    assign ins   = (state_q == ST_RUN) && valid && !(DISTINCT && dup);

    // Outputs are captured from next-state values so done coincides with the final list.
    always_comb begin
        fill_d = fill_q;
        if (clear) begin
            fill_d = '0;
        end else if (ins && taken[K-1] && (fill_q < FILL_W'(K))) begin
            fill_d = fill_q + 1'b1;
        end
        top_d = '0;
        for (int i = 0; i < K; i++) begin
            top_d[i*DATA_W +: DATA_W] = nxt_val[i];
        end
        underfill_d = (fill_d < FILL_W'(K));
        result_d    = underfill_d ? '0 : nxt_val[K-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            fill_q      <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            underfill_q <= 1'b0;
            result_q    <= '0;
            top_q       <= '0;
        end else begin
            fill_q <= fill_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining_q <= count;
                        if (count == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            underfill_q <= underfill_d;
                            result_q    <= result_d;
                            top_q       <= top_d;
                        end else begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (valid) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q     <= ST_DONE;
                            ready_q     <= 1'b0;
                            done_q      <= 1'b1;
                            underfill_q <= underfill_d;
                            result_q    <= result_d;
                            top_q       <= top_d;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign top_flat  = top_q;
    assign underfill = underfill_q;

endmodule

// File: tb/tb_kth_max_tracker.sv
// tb/tb_kth_max_tracker.sv - randomized and directed self-checking bench for kth_max_tracker
module tb_kth_max_tracker;

`ifdef RANK_DISTINCT_EN
    localparam bit DIST = 1'b1;
`else
    localparam bit DIST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, valid;
    logic [2:0]  count;
    logic [7:0]  data_in;
    logic        ready, done, underfill;
    logic [7:0]  result;
    logic [15:0] top_flat;

    logic        s2_start, s2_valid, s2_ready, s2_done, s2_uf;
    logic [2:0]  s2_count;
    logic [15:0] s2_data, s2_result;
    logic [63:0] s2_top;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kth_max_tracker #(.DATA_W(8), .K(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .valid(valid),
        .data_in(data_in), .ready(ready), .done(done), .result(result),
        .top_flat(top_flat), .underfill(underfill)
    );

    kth_max_tracker #(.DATA_W(16), .K(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .start(s2_start), .count(s2_count), .valid(s2_valid),
        .data_in(s2_data), .ready(s2_ready), .done(s2_done), .result(s2_result),
        .top_flat(s2_top), .underfill(s2_uf)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the run's samples are kept as a list and ranked at the end.
    int         m_phase;
    int         m_rem;
    logic [7:0] m_q[$];
    logic       m_ready, m_done, m_uf;
    logic [7:0] m_res;
    logic [15:0] m_top;

    function automatic void model_reset();
        m_phase = 0; m_rem = 0; m_q = {};
        m_ready = 0; m_done = 0; m_uf = 0; m_res = 0; m_top = 0;
    endfunction

    function automatic void model_finish();
        logic [7:0] lst[$];
        bit seen;
        lst = {};
        foreach (m_q[j]) begin
            seen = 0;
            foreach (lst[r]) if (lst[r] == m_q[j]) seen = 1;
            if (!(DIST && seen)) lst.push_back(m_q[j]);
        end
        lst.rsort();
        m_uf  = (lst.size() < 2);
        m_res = m_uf ? 8'd0 : lst[1];
        m_top = '0;
        for (int r = 0; r < 2 && r < lst.size(); r++) m_top[r*8 +: 8] = lst[r];
        m_done = 1;
    endfunction

    function automatic void model_step();
        m_done = 0;
        case (m_phase)
            0: if (start) begin
                m_q = {};
                if (count == 0) begin
                    model_finish(); m_phase = 2;
                end else begin
                    m_rem = count; m_phase = 1; m_ready = 1;
                end
            end
            1: if (valid) begin
                m_q.push_back(data_in);
                m_rem--;
                if (m_rem == 0) begin
                    model_finish(); m_phase = 2; m_ready = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    initial model_reset();

    always @(negedge clk) begin
        if (rst) model_reset();
        check("ready", ready, m_ready);
        check("done", done, m_done);
        check("result", result, m_res);
        check("top_flat", top_flat, m_top);
        check("underfill", underfill, m_uf);
        if (!rst) model_step();
    end

    task automatic do_run(input int cnt, input logic [7:0] s[$], input int gap, input bit noise);
        @(posedge clk); #1;
        start = 1; count = 3'(cnt);
        valid = 1'($urandom % 2); data_in = 8'($urandom);
        @(posedge clk); #1;
        start = 0; valid = 0;
        for (int i = 0; i < cnt; i++) begin
            repeat (gap) begin
                valid = 0; data_in = 8'($urandom);
                start = noise ? 1'($urandom % 2) : 1'b0;
                @(posedge clk); #1;
            end
            start = 0; valid = 1; data_in = s[i];
            @(posedge clk); #1;
        end
        valid = 0; start = 0;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 30);
        check({name, "_latency"}, 64'(c), 64'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        int c;
        rst = 1; start = 0; valid = 0; count = 0; data_in = 0;
        s2_start = 0; s2_valid = 0; s2_count = 0; s2_data = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        q = '{8'd3, 8'd7, 8'd1, 8'd7, 8'd4};
        do_run(5, q, 0, 0);
        wait_done("t1");
        check("t1_result", result, DIST ? 8'd4 : 8'd7);
        check("t1_top", top_flat, DIST ? 16'h0407 : 16'h0707);

        q = '{8'd200};
        do_run(1, q, 0, 0);
        wait_done("t2a");
        check("t2a_uf", underfill, 1);
        check("t2a_result", result, 0);
        check("t2a_top", top_flat, 16'h00C8);

        q = {};
        do_run(0, q, 0, 0);
        wait_done("t2b");
        check("t2b_uf", underfill, 1);

        q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        do_run(7, q, 0, 0);
        wait_done("t4");
        check("t4_result", result, 0);
        check("t4_uf", underfill, DIST ? 1'b1 : 1'b0);

        q = '{8'd10, 8'd20, 8'd30, 8'd5};
        do_run(4, q, 3, 1);
        wait_done("t3");
        check("t3_result", result, 8'd20);
        check("t3_top", top_flat, 16'h141E);

        @(posedge clk); #1;
        start = 1; count = 3'd5;
        @(posedge clk); #1;
        start = 0; valid = 1; data_in = 8'd50;
        @(posedge clk); #1;
        data_in = 8'd60;
        @(posedge clk); #1;
        valid = 0; rst = 1;
        @(negedge clk);
        check("t5_rst_result", result, 0);
        check("t5_rst_top", top_flat, 0);
        check("t5_rst_ready", ready, 0);
        @(posedge clk); #1 rst = 0;
        q = '{8'd9, 8'd8, 8'd7};
        do_run(3, q, 0, 0);
        wait_done("t5");
        check("t5_result", result, 8'd8);
        check("t5_top", top_flat, 16'h0809);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(0, 7);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 12)));
            do_run(n, q, $urandom_range(0, 2), 1);
            wait_done("rand");
        end

        @(posedge clk); #1;
        s2_start = 1; s2_count = 3'd6;
        @(posedge clk); #1;
        s2_start = 0;
        foreach (q[i]) q[i] = 0;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] v[6];
            v = '{16'd100, 16'd900, 16'd300, 16'd900, 16'd50, 16'd700};
            s2_valid = 1; s2_data = v[i];
            @(posedge clk); #1;
        end
        s2_valid = 0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!s2_done && c < 30);
        check("t6_latency", 64'(c), 64'd1);
        check("t6_result", s2_result, DIST ? 16'd100 : 16'd300);
        check("t6_top", s2_top, DIST ? {16'd100, 16'd300, 16'd700, 16'd900}
                                     : {16'd300, 16'd700, 16'd900, 16'd900});
        check("t6_uf", s2_uf, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
